// File: rtl/parent_link_tx_arbiter_pkg.sv
// Shared definitions for the parent-link uplink arbiter and its neighbours.
// Holds the arbiter state type, the uplink width and the message header layout
// that the sources use when they build beats.
package parent_link_pkg;

  localparam int PARENT_LINK_WIDTH = 64;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Message header field offsets within the first beat of a packet.
  localparam int MSG_TYPE_LSB = 60;
  localparam int MSG_TYPE_W   = 4;
  localparam int MSG_DEST_LSB = 48;
  localparam int MSG_DEST_W   = 12;
  localparam int MSG_SRC_LSB  = 36;
  localparam int MSG_SRC_W    = 12;
  localparam int MSG_LEN_LSB  = 28;
  localparam int MSG_LEN_W    = 8;

endpackage

// File: rtl/parent_link_tx_arbiter_if.sv
// Bundle of the per-source request side and the parent_tx uplink side.
// master: the environment (sources + uplink sink); slave: the arbiter.
interface parent_link_tx_arbiter_if #(
  parameter int NUM_SRC       = 4,
  parameter int DATA_WIDTH    = parent_link_pkg::PARENT_LINK_WIDTH,
  parameter int SRC_BIT_WIDTH = $clog2(NUM_SRC)
);

  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC-1:0]            src_ready;
  logic [DATA_WIDTH-1:0]         parent_tx_data;
  logic                          parent_tx_valid;
  logic                          parent_tx_ready;
  logic [SRC_BIT_WIDTH-1:0]      grant_id;
  logic                          grant_active;
  logic                          overrun_err;

  modport master (
    output src_data, src_valid, src_last, parent_tx_ready,
    input  src_ready, parent_tx_data, parent_tx_valid,
    input  grant_id, grant_active, overrun_err
  );

  modport slave (
    input  src_data, src_valid, src_last, parent_tx_ready,
    output src_ready, parent_tx_data, parent_tx_valid,
    output grant_id, grant_active, overrun_err
  );

endinterface

// File: rtl/parent_link_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first requester found
// when scanning upward from ptr with wrap-around. Shared with the root router.
module rr_pick #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_BIT_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]       req,
  input  logic [SRC_BIT_WIDTH-1:0] ptr,
  output logic                     found,
  output logic [SRC_BIT_WIDTH-1:0] index
);

  logic [SRC_BIT_WIDTH-1:0] cand_s;

  // Scan NUM_SRC candidates starting at ptr; the first requester wins.
  always_comb begin
    found  = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_s = SRC_BIT_WIDTH'((int'(ptr) + i) % NUM_SRC);
      if (!found && req[cand_s]) begin
        found = 1'b1;
        index = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/parent_link_tx_arbiter.sv
// Packet-granular round-robin arbiter for the leaf FPGA parent_tx uplink.
// A granted source keeps the link until its last beat (or until the beat
// watchdog forces release at MAX_BEATS). One registered output stage.
// Optional build macro ARB_SRC0_PRIORITY_EN: source 0 wins every idle
// arbitration and does not move the rotation pointer.
module parent_link_tx_arbiter
  import parent_link_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int DATA_WIDTH    = PARENT_LINK_WIDTH,
  parameter int MAX_BEATS     = 16,
  parameter int SRC_BIT_WIDTH = $clog2(NUM_SRC)
) (
  input logic                      clk,
  input logic                      reset,
  parent_link_tx_arbiter_if.slave  bus
);

  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_BEATS);

  arb_state_t               state_r;
  logic [SRC_BIT_WIDTH-1:0] rr_ptr_r;
  logic [CNT_WIDTH-1:0]     beat_cnt_r;
  logic                     out_valid_r;
  logic [DATA_WIDTH-1:0]    out_data_r;
  logic [SRC_BIT_WIDTH-1:0] grant_id_r;
  logic                     grant_active_r;
  logic                     overrun_err_r;

  logic                     pick_found_s;
  logic [SRC_BIT_WIDTH-1:0] pick_idx_s;
  logic                     sel_found_s;
  logic [SRC_BIT_WIDTH-1:0] sel_idx_s;
  logic                     can_load_s;
  logic [SRC_BIT_WIDTH-1:0] owner_s;
  logic                     owner_ok_s;
  logic [NUM_SRC-1:0]       src_ready_s;
  logic                     xfer_s;
  logic                     xfer_last_s;
  logic [DATA_WIDTH-1:0]    xfer_data_s;

  // Rotation pointer after source s finishes a packet.
  function automatic logic [SRC_BIT_WIDTH-1:0] advance_ptr(
    input logic [SRC_BIT_WIDTH-1:0] cur_ptr,
    input logic [SRC_BIT_WIDTH-1:0] s
  );
`ifdef ARB_SRC0_PRIORITY_EN
    if (s == '0) begin
      return cur_ptr;
    end else if (int'(s) == NUM_SRC - 1) begin
      return '0;
    end else begin
      return s + SRC_BIT_WIDTH'(1);
    end
`else
    if (int'(s) == NUM_SRC - 1) begin
      return (cur_ptr & '0);
    end else begin
      return s + SRC_BIT_WIDTH'(1);
    end
`endif
  endfunction

  rr_pick #(
    .NUM_SRC       (NUM_SRC),
    .SRC_BIT_WIDTH (SRC_BIT_WIDTH)
  ) u_rr_pick (
    .req   (bus.src_valid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .index (pick_idx_s)
  );

`ifdef ARB_SRC0_PRIORITY_EN
  // Source 0 overrides the rotation whenever it is requesting.
  always_comb begin
    if (bus.src_valid[0]) begin
      sel_found_s = 1'b1;
      sel_idx_s   = '0;
    end else begin
      sel_found_s = pick_found_s;
      sel_idx_s   = pick_idx_s;
    end
  end
`else
  // Pure round-robin: take the picker result as is.
  always_comb begin
    sel_found_s = pick_found_s;
    sel_idx_s   = pick_idx_s;
  end
`endif

  // Decide who may push a beat this cycle and whether a transfer happens.
  always_comb begin
    can_load_s  = !out_valid_r || bus.parent_tx_ready;
    owner_s     = grant_id_r;
    owner_ok_s  = 1'b0;
    src_ready_s = '0;
    case (state_r)
      ARB_IDLE: begin
        owner_s    = sel_idx_s;
        owner_ok_s = sel_found_s;
      end
      ARB_LOCKED: begin
        owner_s    = grant_id_r;
        owner_ok_s = 1'b1;
      end
      default: begin
        owner_s    = grant_id_r;
        owner_ok_s = 1'b0;
      end
    endcase
    if (can_load_s && owner_ok_s) begin
      src_ready_s[owner_s] = 1'b1;
    end else begin
      src_ready_s = '0;
    end
    xfer_s      = can_load_s && owner_ok_s && bus.src_valid[owner_s];
    xfer_last_s = bus.src_last[owner_s];
    xfer_data_s = bus.src_data[int'(owner_s) * DATA_WIDTH +: DATA_WIDTH];
  end

  // Output register, arbitration FSM, beat counter and overrun watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ARB_IDLE;
      rr_ptr_r       <= '0;
      beat_cnt_r     <= '0;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      grant_id_r     <= '0;
      grant_active_r <= 1'b0;
      overrun_err_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= xfer_data_s;
      end else if (bus.parent_tx_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state_r)
        ARB_IDLE: begin
          if (xfer_s) begin
            if (xfer_last_s) begin
              rr_ptr_r <= advance_ptr(rr_ptr_r, owner_s);
            end else begin
              state_r        <= ARB_LOCKED;
              grant_id_r     <= owner_s;
              grant_active_r <= 1'b1;
              beat_cnt_r     <= CNT_ONE;
            end
          end
        end
        ARB_LOCKED: begin
          if (xfer_s) begin
            if (xfer_last_s || (beat_cnt_r == CNT_LAST)) begin
              // A missing last at the beat limit is forced to close the packet.
              if (!xfer_last_s) begin
                overrun_err_r <= 1'b1;
              end
              state_r        <= ARB_IDLE;
              grant_active_r <= 1'b0;
              beat_cnt_r     <= '0;
              rr_ptr_r       <= advance_ptr(rr_ptr_r, grant_id_r);
            end else if (beat_cnt_r != CNT_MAX) begin
              beat_cnt_r <= beat_cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready       = src_ready_s;
  assign bus.parent_tx_data  = out_data_r;
  assign bus.parent_tx_valid = out_valid_r;
  assign bus.grant_id        = grant_id_r;
  assign bus.grant_active    = grant_active_r;
  assign bus.overrun_err     = overrun_err_r;

endmodule

// File: tb/tb_parent_link_tx_arbiter.sv
// Self-checking bench for parent_link_tx_arbiter. Sources are packet queues;
// a transaction-level reference model tracks link ownership, the rotation
// pointer and the one-entry output stage, and every cycle is compared.
module tb_parent_link_tx_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parent_link_tx_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  parent_link_tx_arbiter #(
    .NUM_SRC   (NS),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Source packet queues: bit 64 = last, bits 63:0 = beat data.
  logic [64:0] q[NS][$];
  int pkt_id[NS];
  int gate_pct = 100;
  int rdy_mode = 1;  // 0 random, 1 high, 2 low

  // Reference model state.
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  int          m_cnt;
  bit          m_ovalid;
  logic [63:0] m_odata;
  int          m_gid;
  bit          m_gact;
  bit          m_ovr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ptr(input int s);
`ifdef ARB_SRC0_PRIORITY_EN
    if (s == 0) return m_ptr;
`endif
    return (s + 1) % NS;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < NS; s++) n += q[s].size();
    return n;
  endfunction

  task automatic add_pkt(input int s, input int len);
    logic [64:0] b;
    for (int i = 0; i < len; i++) begin
      b[63:0] = {8'(s), 16'(pkt_id[s]), 8'(i), 32'($urandom)};
      b[64]   = (i == len - 1);
      q[s].push_back(b);
    end
    pkt_id[s]++;
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_ovalid = 1'b0; m_odata = 64'd0; m_gid = 0; m_gact = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.src_valid = '0;
    bus.src_last = '0;
    bus.parent_tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx_valid", 64'(bus.parent_tx_valid), 64'd0);
    check("rst_tx_data", bus.parent_tx_data, 64'd0);
    check("rst_src_ready", 64'(bus.src_ready), 64'd0);
    check("rst_grant_active", 64'(bus.grant_active), 64'd0);
    check("rst_grant_id", 64'(bus.grant_id), 64'd0);
    check("rst_overrun", 64'(bus.overrun_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: drive sources, compare against the model, advance the model.
  task automatic step();
    logic [NS-1:0]    v;
    logic [NS-1:0]    l;
    logic [NS*DW-1:0] dv;
    logic [NS-1:0]    er;
    logic             rdy;
    int               cand;
    int               s;
    bit               can;
    bit               xfer;
    @(negedge clk);
    v = '0; l = '0; dv = '0;
    for (int k = 0; k < NS; k++) begin
      if (q[k].size() > 0 && $urandom_range(0, 99) < gate_pct) begin
        v[k] = 1'b1;
        l[k] = q[k][0][64];
        dv[k*DW +: DW] = q[k][0][63:0];
      end
    end
    case (rdy_mode)
      1: rdy = 1'b1;
      2: rdy = 1'b0;
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    bus.src_valid = v;
    bus.src_last = l;
    bus.src_data = dv;
    bus.parent_tx_ready = rdy;
    #1;
    check("tx_valid", 64'(bus.parent_tx_valid), 64'(m_ovalid));
    if (m_ovalid) check("tx_data", bus.parent_tx_data, m_odata);
    check("grant_active", 64'(bus.grant_active), 64'(m_gact));
    check("grant_id", 64'(bus.grant_id), 64'(m_gid));
    check("overrun_err", 64'(bus.overrun_err), 64'(m_ovr));

    cand = -1;
    if (m_locked) begin
      cand = m_owner;
    end else begin
`ifdef ARB_SRC0_PRIORITY_EN
      if (v[0]) cand = 0;
`endif
      for (int i = 0; i < NS; i++) begin
        s = (m_ptr + i) % NS;
        if (cand < 0 && v[s]) cand = s;
      end
    end
    can = !m_ovalid || rdy;
    er = '0;
    if (can && cand >= 0) er[cand] = 1'b1;
    check("src_ready", 64'(bus.src_ready), 64'(er));
    xfer = can && cand >= 0 && v[cand];

    @(posedge clk);
    if (xfer) begin
      m_ovalid = 1'b1;
      m_odata = dv[cand*DW +: DW];
      void'(q[cand].pop_front());
      if (!m_locked) begin
        if (l[cand]) begin
          m_ptr = next_ptr(cand);
        end else begin
          m_locked = 1'b1; m_owner = cand; m_gid = cand; m_gact = 1'b1; m_cnt = 1;
        end
      end else if (l[cand] || m_cnt == MB - 1) begin
        if (!l[cand]) m_ovr = 1'b1;
        m_locked = 1'b0; m_gact = 1'b0; m_cnt = 0;
        m_ptr = next_ptr(cand);
      end else begin
        m_cnt++;
      end
    end else if (rdy) begin
      m_ovalid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((pending() > 0 || m_ovalid) && c < budget) begin
      step();
      c++;
    end
    check("drain_left", 64'(pending()), 64'd0);
  endtask

  logic [63:0] b1;

  initial begin
    reset = 1'b1;
    bus.src_data = '0;
    bus.src_valid = '0;
    bus.src_last = '0;
    bus.parent_tx_ready = 1'b0;
    for (int s = 0; s < NS; s++) pkt_id[s] = 0;
    model_reset();
    do_reset();

    // Two 3-beat packets, no interleave, source 1 first.
    gate_pct = 100; rdy_mode = 1;
    add_pkt(1, 3);
    add_pkt(2, 3);
    drain(50);
    #1;
    check("two_pkt_last_owner", 64'(bus.grant_id), 64'd2);

    // Continuous single-beat packets from every source.
    for (int k = 0; k < 8; k++)
      for (int s = 0; s < NS; s++) add_pkt(s, 1);
    drain(100);

    // Backpressure holds the first beat stable.
    add_pkt(0, 3);
    b1 = q[0][0][63:0];
    rdy_mode = 1;
    step();
    rdy_mode = 2;
    repeat (5) begin
      step();
      #1;
      check("hold_data", bus.parent_tx_data, b1);
    end
    rdy_mode = 1;
    drain(50);

    // Watchdog: 20 beats with last only on the final one.
    add_pkt(3, 20);
    repeat (10) step();
    add_pkt(0, 2);
    drain(100);
    #1;
    check("overrun_sticky", 64'(bus.overrun_err), 64'd1);

    // Reset in the middle of a packet; source 2 then goes first.
    do_reset();
    add_pkt(1, 4);
    add_pkt(2, 2);
    step();
    step();
    q[1].delete();
    do_reset();
    step();
    #1;
    check("post_reset_owner", 64'(bus.grant_id), 64'd2);
    drain(50);

    // Randomized traffic with gaps and random backpressure.
    for (int r = 0; r < 4; r++) begin
      gate_pct = 70; rdy_mode = 0;
      for (int s = 0; s < NS; s++)
        repeat ($urandom_range(1, 4))
          add_pkt(s, ($urandom_range(0, 7) == 0) ? 18 : $urandom_range(1, 6));
      repeat (30) step();
      drain(3000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
